// File: rtl/prbs_checker_pkg.sv
// Shared types and the XNOR LFSR tap table used by both the PRBS generator and checker.
// Taps follow the XAPP052 maximal-length XNOR table for widths 3..32.
package prbs_pkg;

    typedef enum logic [1:0] {
        ST_FILL   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_LOCKED = 2'd2
    } state_e;

    localparam int LFSR_MAX_W = 32;

    // Bit k-1 set means tap k; bit n-1 is the oldest bit of the shift register.
    function automatic logic [31:0] lfsr_taps(input logic [5:0] n);
        logic [31:0] mask;
        case (n)
            6'd3:    mask = 32'h0000_0006;
            6'd4:    mask = 32'h0000_000C;
            6'd5:    mask = 32'h0000_0014;
            6'd6:    mask = 32'h0000_0030;
            6'd7:    mask = 32'h0000_0060;
            6'd8:    mask = 32'h0000_00B8;
            6'd9:    mask = 32'h0000_0110;
            6'd10:   mask = 32'h0000_0240;
            6'd11:   mask = 32'h0000_0500;
            6'd12:   mask = 32'h0000_0829;
            6'd13:   mask = 32'h0000_100D;
            6'd14:   mask = 32'h0000_2015;
            6'd15:   mask = 32'h0000_6000;
            6'd16:   mask = 32'h0000_D008;
            6'd17:   mask = 32'h0001_2000;
            6'd18:   mask = 32'h0002_0400;
            6'd19:   mask = 32'h0004_0023;
            6'd20:   mask = 32'h0009_0000;
            6'd21:   mask = 32'h0014_0000;
            6'd22:   mask = 32'h0030_0000;
            6'd23:   mask = 32'h0042_0000;
            6'd24:   mask = 32'h00E1_0000;
            6'd25:   mask = 32'h0120_0000;
            6'd26:   mask = 32'h0200_0023;
            6'd27:   mask = 32'h0400_0013;
            6'd28:   mask = 32'h0900_0000;
            6'd29:   mask = 32'h1400_0000;
            6'd30:   mask = 32'h2000_0029;
            6'd31:   mask = 32'h4800_0000;
            6'd32:   mask = 32'h8020_0003;
            default: mask = 32'h0000_00B8;
        endcase
        return mask;
    endfunction

    function automatic logic lfsr_fb(input logic [5:0] n, input logic [31:0] vec);
        return ~(^(vec & lfsr_taps(n)));
    endfunction

endpackage

// File: rtl/prbs_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over a same-cycle increment.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] r_count;

    // Count register: clear, then increment only below all-ones
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_count <= '0;
        end else if (clr_i) begin
            r_count <= '0;
        end else if (inc_i && !(&r_count)) begin
            r_count <= r_count + W'(1);
        end else begin
            r_count <= r_count;
        end
    end

    assign count_o = r_count;

endmodule

// File: rtl/prbs_checker.sv
// Self-synchronising serial PRBS checker with lock detection and BER counters.
// Optional all-ones lock-up detection is enabled by defining PRBS_STUCK_DET_EN.
module prbs_checker
    import prbs_pkg::*;
#(
    parameter int N          = 8,
    parameter int LOCK_CNT   = 16,
    parameter int WIN        = 64,
    parameter int UNLOCK_ERR = 4,
    parameter int CNT_W      = 32
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             clk_en_i,
    input  logic             data_i,
    input  logic             clr_i,
    output logic             locked_o,
    output logic             err_o,
    output logic [CNT_W-1:0] bit_cnt_o,
    output logic [CNT_W-1:0] err_cnt_o,
    output logic             stuck_o
);

    localparam logic [5:0] LP_N   = 6'(N);
    localparam int         WIN_W  = $clog2(WIN);
    localparam int         WERR_W = $clog2(WIN) + 1;

    state_e              r_state;
    logic [N-1:0]        r_shift;
    logic [7:0]          r_cnt;
    logic [WIN_W-1:0]    r_win_cnt;
    logic [WERR_W-1:0]   r_win_err;
    logic                r_err;

    logic                w_expected;
    logic                w_mismatch;
    logic                w_locked;
    logic                w_inc_bit;
    logic                w_inc_err;
    logic [WERR_W-1:0]   w_win_err_nxt;
    logic                w_unlock;
    logic                w_stuck_hit;

    assign w_expected    = lfsr_fb(LP_N, 32'(r_shift));
    assign w_mismatch    = data_i ^ w_expected;
    assign w_locked      = (r_state == ST_LOCKED);
    assign w_inc_bit     = clk_en_i & w_locked;
    assign w_inc_err     = w_inc_bit & w_mismatch;
    assign w_win_err_nxt = r_win_err + {{(WERR_W-1){1'b0}}, w_mismatch};
    assign w_unlock      = w_mismatch && (w_win_err_nxt == WERR_W'(UNLOCK_ERR));

    // Lock FSM: r_cnt counts fill bits in FILL and consecutive matches in SEARCH
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state   <= ST_FILL;
            r_shift   <= '0;
            r_cnt     <= 8'd0;
            r_win_cnt <= '0;
            r_win_err <= '0;
            r_err     <= 1'b0;
        end else begin
            r_err <= w_inc_err;
            if (clk_en_i) begin
                case (r_state)
                    ST_FILL: begin
                        r_shift <= {r_shift[N-2:0], data_i};
                        if (r_cnt == 8'(N - 1)) begin
                            r_state <= ST_SEARCH;
                            r_cnt   <= 8'd0;
                        end else begin
                            r_cnt <= r_cnt + 8'd1;
                        end
                    end
                    ST_SEARCH: begin
                        r_shift <= {r_shift[N-2:0], data_i};
                        if (w_mismatch) begin
                            r_cnt <= 8'd0;
                        end else if (r_cnt == 8'(LOCK_CNT - 1)) begin
                            r_state   <= ST_LOCKED;
                            r_cnt     <= 8'd0;
                            r_win_cnt <= '0;
                            r_win_err <= '0;
                        end else begin
                            r_cnt <= r_cnt + 8'd1;
                        end
                    end
                    ST_LOCKED: begin
                        // Free-run so a corrupted bit never pollutes the reference
                        r_shift   <= {r_shift[N-2:0], w_expected};
                        r_win_cnt <= r_win_cnt + WIN_W'(1);
                        if (w_unlock) begin
                            r_state <= ST_SEARCH;
                            r_cnt   <= 8'd0;
                        end else if (&r_win_cnt) begin
                            r_win_err <= '0;
                        end else begin
                            r_win_err <= w_win_err_nxt;
                        end
                    end
                    default: begin
                        r_state <= ST_FILL;
                        r_cnt   <= 8'd0;
                    end
                endcase
                if (w_stuck_hit) begin
                    r_state <= ST_SEARCH;
                    r_cnt   <= 8'd0;
                end
            end
        end
    end

`ifdef PRBS_STUCK_DET_EN
    logic [5:0] r_run;
    logic       r_stuck;

    assign w_stuck_hit = data_i && (r_run >= (LP_N - 6'd1));

    // Run length of consecutive ones, saturating at N
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_run   <= 6'd0;
            r_stuck <= 1'b0;
        end else if (clk_en_i) begin
            if (!data_i) begin
                r_run   <= 6'd0;
                r_stuck <= 1'b0;
            end else begin
                r_run <= (r_run == LP_N) ? r_run : r_run + 6'd1;
                if (w_stuck_hit) begin
                    r_stuck <= 1'b1;
                end else begin
                    r_stuck <= r_stuck;
                end
            end
        end else begin
            r_run   <= r_run;
            r_stuck <= r_stuck;
        end
    end

    assign stuck_o = r_stuck;
`else
    assign w_stuck_hit = 1'b0;
    assign stuck_o     = 1'b0;
`endif

    sat_counter #(.W(CNT_W)) u_bit_cnt (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .clr_i   (clr_i),
        .inc_i   (w_inc_bit),
        .count_o (bit_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_err_cnt (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .clr_i   (clr_i),
        .inc_i   (w_inc_err),
        .count_o (err_cnt_o)
    );

    assign locked_o = w_locked;
    assign err_o    = r_err;

endmodule

// File: tb/tb_prbs_checker.sv
// Directed bench for prbs_checker: a sequence-level reference model checked every cycle,
// plus hand-computed literal expectations for lock latency, error counts and saturation.
module tb_prbs_checker;

    localparam int N          = 8;
    localparam int LOCK_CNT   = 16;
    localparam int WIN        = 64;
    localparam int UNLOCK_ERR = 4;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        clk_en_i;
    logic        data_i;
    logic        clr_i;
    logic        locked_a, err_a, stuck_a;
    logic [31:0] bit_a, errc_a;
    logic        locked_b, err_b, stuck_b;
    logic [3:0]  bit_b, errc_b;

    always #5 clk_i = ~clk_i;

    prbs_checker #(.N(N), .LOCK_CNT(LOCK_CNT), .WIN(WIN), .UNLOCK_ERR(UNLOCK_ERR), .CNT_W(32)) u_dut_a (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .clk_en_i(clk_en_i), .data_i(data_i), .clr_i(clr_i),
        .locked_o(locked_a), .err_o(err_a), .bit_cnt_o(bit_a), .err_cnt_o(errc_a), .stuck_o(stuck_a)
    );

    prbs_checker #(.N(N), .LOCK_CNT(LOCK_CNT), .WIN(WIN), .UNLOCK_ERR(UNLOCK_ERR), .CNT_W(4)) u_dut_b (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .clk_en_i(clk_en_i), .data_i(data_i), .clr_i(clr_i),
        .locked_o(locked_b), .err_o(err_b), .bit_cnt_o(bit_b), .err_cnt_o(errc_b), .stuck_o(stuck_b)
    );

    int nchk = 0;
    int nerr = 0;

    // Reference model: 0=fill 1=search 2=locked; counts are true (unsaturated) totals
    int     m_state, m_fill, m_match, m_win_pos, m_win_err, m_run;
    bit     m_err, m_stuck;
    longint m_bits, m_errs;
    int     m_q[$];
    int     g_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic longint sat(input longint v, input int w);
        longint top;
        top = (longint'(1) << w) - 1;
        return (v > top) ? top : v;
    endfunction

    // Generator: bit k = XNOR(b[k-8], b[k-6], b[k-5], b[k-4])
    function automatic bit gen_next();
        bit nb;
        nb = !(g_q[0] ^ g_q[2] ^ g_q[3] ^ g_q[4]);
        g_q.push_back(int'(nb));
        void'(g_q.pop_front());
        return nb;
    endfunction

    task automatic model_reset();
        m_state = 0; m_fill = 0; m_match = 0; m_win_pos = 0; m_win_err = 0; m_run = 0;
        m_err = 0; m_stuck = 0; m_bits = 0; m_errs = 0;
        m_q.delete();
    endtask

    task automatic model_push(input bit b);
        m_q.push_back(int'(b));
        if (m_q.size() > N) void'(m_q.pop_front());
    endtask

    task automatic model_update(input bit en, input bit d, input bit clr);
        bit pred;
        m_err = 0;
        if (en) begin
            pred = (m_q.size() == N) ? !(m_q[0] ^ m_q[2] ^ m_q[3] ^ m_q[4]) : 1'b0;
            case (m_state)
                0: begin
                    model_push(d);
                    m_fill++;
                    if (m_fill == N) begin m_state = 1; m_match = 0; end
                end
                1: begin
                    model_push(d);
                    if (d == pred) m_match++; else m_match = 0;
                    if (m_match == LOCK_CNT) begin m_state = 2; m_win_pos = 0; m_win_err = 0; end
                end
                default: begin
                    model_push(pred);
                    m_bits++;
                    if (d != pred) begin m_errs++; m_win_err++; m_err = 1; end
                    if (m_win_err == UNLOCK_ERR) begin
                        m_state = 1; m_match = 0;
                    end else begin
                        m_win_pos++;
                        if (m_win_pos == WIN) begin m_win_pos = 0; m_win_err = 0; end
                    end
                end
            endcase
`ifdef PRBS_STUCK_DET_EN
            m_run = d ? m_run + 1 : 0;
            if (!d) m_stuck = 0;
            if (m_run >= N) begin m_stuck = 1; m_state = 1; m_match = 0; end
`endif
        end
        if (clr) begin m_bits = 0; m_errs = 0; end
    endtask

    task automatic check_all();
        chk("locked",   64'(locked_a), 64'(m_state == 2));
        chk("err_o",    64'(err_a),    64'(m_err));
        chk("stuck",    64'(stuck_a),  64'(m_stuck));
        chk("bit_cnt",  64'(bit_a),    64'(sat(m_bits, 32)));
        chk("err_cnt",  64'(errc_a),   64'(sat(m_errs, 32)));
        chk("locked_b", 64'(locked_b), 64'(m_state == 2));
        chk("err_b",    64'(err_b),    64'(m_err));
        chk("stuck_b",  64'(stuck_b),  64'(m_stuck));
        chk("bit_b",    64'(bit_b),    64'(sat(m_bits, 4)));
        chk("errc_b",   64'(errc_b),   64'(sat(m_errs, 4)));
    endtask

    // Entered and left at a falling edge: compare, drive, advance model, clock once
    task automatic step(input bit en, input bit d, input bit clr);
        check_all();
        clk_en_i = en; data_i = d; clr_i = clr;
        model_update(en, d, clr);
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic run_clean(input int n);
        for (int i = 0; i < n; i++) step(1'b1, gen_next(), 1'b0);
    endtask

    task automatic inject();
        step(1'b1, !gen_next(), 1'b0);
    endtask

    task automatic async_reset();
        #2 rst_n_i = 1'b0;
        clk_en_i = 1'b0; data_i = 1'b0; clr_i = 1'b0;
        #1;
        chk("rst_locked", 64'(locked_a), 64'd0);
        chk("rst_err",    64'(err_a),    64'd0);
        chk("rst_bits",   64'(bit_a),    64'd0);
        chk("rst_errs",   64'(errc_a),   64'd0);
        chk("rst_stuck",  64'(stuck_a),  64'd0);
        model_reset();
        @(negedge clk_i);
        rst_n_i = 1'b1;
    endtask

    initial begin
        int  en_cnt;
        int  cyc;
        bit  en;
        bit  early;
        for (int i = 0; i < N; i++) g_q.push_back(0);
        rst_n_i = 1'b0; clk_en_i = 1'b0; data_i = 1'b0; clr_i = 1'b0;
        model_reset();
        repeat (2) @(negedge clk_i);
        chk("reset_locked", 64'(locked_a), 64'd0);
        chk("reset_err",    64'(err_a),    64'd0);
        chk("reset_bits",   64'(bit_a),    64'd0);
        chk("reset_errs",   64'(errc_a),   64'd0);
        chk("reset_stuck",  64'(stuck_a),  64'd0);
        rst_n_i = 1'b1;

        // Scenario 1: lock after fill (8) + 16 matches, then 1000 clean locked bits
        run_clean(23);
        chk("lock_not_at_23", 64'(locked_a), 64'd0);
        run_clean(1);
        chk("lock_at_24", 64'(locked_a), 64'd1);
        run_clean(1000);
        chk("bits_1000", 64'(bit_a), 64'd1000);
        chk("errs_0",    64'(errc_a), 64'd0);
        chk("bits_sat4", 64'(bit_b), 64'd15);

        // Scenario 2: a single inverted bit is counted once
        inject();
        chk("single_err_pulse", 64'(err_a), 64'd1);
        run_clean(1);
        chk("pulse_one_cycle", 64'(err_a), 64'd0);
        run_clean(10);
        chk("single_err_cnt", 64'(errc_a), 64'd1);
        chk("still_locked",   64'(locked_a), 64'd1);

        // Scenario 3: four errors inside one window drop lock, clean bits relock
        step(1'b1, gen_next(), 1'b1);
        chk("clr_clean", 64'(errc_a), 64'd0);
        for (int i = 0; i < 200 && m_win_pos != 0; i++) run_clean(1);
        for (int k = 0; k < 3; k++) begin inject(); run_clean(2); end
        chk("locked_after_3", 64'(locked_a), 64'd1);
        inject();
        chk("unlock_on_4th", 64'(locked_a), 64'd0);
        chk("errs_4",        64'(errc_a),   64'd4);
        run_clean(15);
        chk("no_relock_15", 64'(locked_a), 64'd0);
        run_clean(1);
        chk("relock_16", 64'(locked_a), 64'd1);

        // Scenario 4: clear beats a same-edge error; 4-bit counter saturates at 15
        run_clean(100);
        step(1'b1, !gen_next(), 1'b1);
        chk("clr_beats_err", 64'(errc_a), 64'd0);
        chk("clr_err_pulse", 64'(err_a),  64'd1);
        run_clean(70);
        inject();
        chk("err_after_clr", 64'(errc_a), 64'd1);
        step(1'b1, gen_next(), 1'b1);
        for (int k = 0; k < 20; k++) begin run_clean(70); inject(); end
        chk("errs_20",      64'(errc_a),   64'd20);
        chk("errs_sat_15",  64'(errc_b),   64'd15);
        chk("locked_sparse", 64'(locked_a), 64'd1);

        // Scenario 5: reset while locked, then 30% bit-strobe duty
        async_reset();
        en_cnt = 0; cyc = 0; early = 0;
        while (en_cnt < 24 && cyc < 2000) begin
            en = ($urandom_range(0, 99) < 30);
            if (en) begin step(1'b1, gen_next(), 1'b0); en_cnt++; end
            else step(1'b0, 1'($urandom_range(0, 1)), 1'b0);
            if (en_cnt < 24 && locked_a) early = 1;
            cyc++;
        end
        chk("rand_no_early_lock", 64'(early),    64'd0);
        chk("rand_lock_24",       64'(locked_a), 64'd1);
        en_cnt = 0; cyc = 0;
        while (en_cnt < 1000 && cyc < 10000) begin
            en = ($urandom_range(0, 99) < 30);
            if (en) begin step(1'b1, gen_next(), 1'b0); en_cnt++; end
            else step(1'b0, 1'($urandom_range(0, 1)), 1'b0);
            cyc++;
        end
        chk("rand_bits_1000", 64'(bit_a),  64'd1000);
        chk("rand_errs_0",    64'(errc_a), 64'd0);

        // Scenario 6: all-ones lock-up stream
        async_reset();
`ifdef PRBS_STUCK_DET_EN
        for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 1'b0);
        chk("stuck_not_at_7", 64'(stuck_a), 64'd0);
        step(1'b1, 1'b1, 1'b0);
        chk("stuck_at_8", 64'(stuck_a), 64'd1);
        for (int i = 0; i < 100; i++) step(1'b1, 1'b1, 1'b0);
        chk("stuck_no_lock", 64'(locked_a), 64'd0);
        step(1'b1, 1'b0, 1'b0);
        chk("stuck_clears", 64'(stuck_a), 64'd0);
`else
        for (int i = 0; i < 23; i++) step(1'b1, 1'b1, 1'b0);
        chk("ones_not_at_23", 64'(locked_a), 64'd0);
        step(1'b1, 1'b1, 1'b0);
        chk("ones_false_lock", 64'(locked_a), 64'd1);
        chk("ones_stuck_0",    64'(stuck_a),  64'd0);
`endif
        check_all();
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
